// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one shift-and-subtract step per clock
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             DZ
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, quo, quo_nx;
  logic [WIDTH:0] rem, rem_sh, rem_nx;
  logic [WIDTH+1:0] sum;
  logic [CW-1:0] cnt;
  logic accept, no_borrow;
  assign accept = start && (state != S_CALC);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = accept ? ((B == '0) ? S_DONE : S_CALC)
             : (state == S_CALC) ? ((cnt == '0) ? S_DONE : S_CALC)
             : S_IDLE;
  end
  always_comb begin
    busy = state == S_CALC;
    done = state == S_DONE;
  end
  // Subtract by complement: the carry out of the wide sum is the inverted borrow.
  always_comb begin
    rem_sh = (rem << 1) | (WIDTH+1)'(a_q[WIDTH-1]);
    sum = {1'b0, rem_sh} + {1'b0, ~{1'b0, b_q}} + (WIDTH+2)'(1);
    no_borrow = sum[WIDTH+1];
    rem_nx = no_borrow ? sum[WIDTH:0] : rem_sh;
    quo_nx = (quo << 1) | WIDTH'(no_borrow);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      Q <= '0;
      R <= '0;
      DZ <= 1'b0;
    end else if (accept) begin
      a_q <= A;
      b_q <= B;
      rem <= '0;
      quo <= '0;
      cnt <= CW'(WIDTH-1);
      if (B == '0) begin
        Q <= '1;
        R <= A;
        DZ <= 1'b1;
      end
    end else if (state == S_CALC) begin
      a_q <= a_q << 1;
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        Q <= quo_nx;
        R <= rem_nx[WIDTH-1:0];
        DZ <= 1'b0;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider against an arithmetic model
module tb_seq_divider;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] A = '0, B = '0, Q, R;
  logic busy, done, DZ;
  int n_chk = 0, n_fail = 0;
  logic [2*W:0] sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .DZ(DZ)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W:0] ref_div(int a, int b);
    return (b == 0) ? {{W{1'b1}}, W'(a), 1'b1} : {W'(a / b), W'(a % b), 1'b0};
  endfunction

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [2*W:0] e;
    if (rst_n) begin
      check("busy_done_exclusive", int'(busy && done), 0);
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("Q", int'(Q), int'(e[2*W:W+1]));
          check("R", int'(R), int'(e[W:1]));
          check("DZ", int'(DZ), int'(e[0]));
        end
      end
    end
  end

  // Called just after a falling edge; returns at the falling edge where done is seen.
  task automatic run_div(int a, int b);
    int busy_n = 0;
    bit got = 0;
    start = 1'b1;
    A = W'(a);
    B = W'(b);
    sb.push_back(ref_div(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (busy) busy_n++;
    end
    check("done_timeout", int'(got), 1);
    check("busy_cycles", busy_n, (b == 0) ? 0 : W);
  endtask

  initial begin
    int done_n;
    bit got;
    #1 rst_n = 1'b0;
    #1;
    check("rst_Q", int'(Q), 0);
    check("rst_R", int'(R), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_DZ", int'(DZ), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_div(13, 4);
    @(negedge clk);
    run_div(15, 1);
    @(negedge clk);
    run_div(3, 9);
    @(negedge clk);
    run_div(7, 0);
    @(negedge clk);
    // start held through CALC with changing operands must not disturb the result
    start = 1'b1;
    A = 4'd12;
    B = 4'd5;
    sb.push_back(ref_div(12, 5));
    @(posedge clk);
    #1;
    A = 4'd2;
    B = 4'd1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        start = 1'b0;
      end
    end
    check("held_start_timeout", int'(got), 1);
    done_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("held_start_single_done", done_n, 0);
    // reset on the second CALC cycle abandons the division
    start = 1'b1;
    A = 4'd9;
    B = 4'd2;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_Q", int'(Q), 0);
    check("midrst_R", int'(R), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_DZ", int'(DZ), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_div(9, 2);
    run_div(14, 3);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        run_div(a, b);
      end
    repeat (40) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      run_div(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
